// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit: stage records, forwarding
// select codes and the saturating Tnew decrement.
package hazard_pkg;

    localparam int TW = 2;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

    typedef struct packed {
        logic          wr;
        logic [4:0]    addr;
        logic [TW-1:0] tnew;
        logic [4:0]    rs;
        logic [4:0]    rt;
    } e_stage_t;

    typedef struct packed {
        logic          wr;
        logic [4:0]    addr;
        logic [TW-1:0] tnew;
        logic [4:0]    rt;
    } m_stage_t;

    typedef struct packed {
        logic       wr;
        logic [4:0] addr;
    } w_stage_t;

    // Tnew counts down one per stage but never wraps below zero.
    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        if (x == {TW{1'b0}}) begin
            return {TW{1'b0}};
        end else begin
            return x - TW'(1);
        end
    endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Checks one D-stage source register against the E/M/W producers and returns the
// stall request plus the D-stage forwarding select for that source.
module hazard_src_check
    import hazard_pkg::*;
(
    input  logic [4:0]    src,
    input  logic          used,
    input  logic [TW-1:0] tuse,
    input  logic          e_wr,
    input  logic [4:0]    e_addr,
    input  logic [TW-1:0] e_tnew,
    input  logic          m_wr,
    input  logic [4:0]    m_addr,
    input  logic [TW-1:0] m_tnew,
    input  logic          w_wr,
    input  logic [4:0]    w_addr,
    output logic          stall_req,
    output logic [1:0]    fwd_sel
);

    logic match_e_s;
    logic match_m_s;
    logic match_w_s;

    assign match_e_s = e_wr && (e_addr == src) && (src != 5'd0);
    assign match_m_s = m_wr && (m_addr == src) && (src != 5'd0);
    assign match_w_s = w_wr && (w_addr == src) && (src != 5'd0);

    // Stall while a matching producer cannot deliver before this source is needed.
    always_comb begin
        stall_req = 1'b0;
        if (used && ((match_e_s && (e_tnew > tuse)) || (match_m_s && (m_tnew > tuse)))) begin
            stall_req = 1'b1;
        end else begin
            stall_req = 1'b0;
        end
    end

    // Nearest matching producer decides; one still computing blocks older copies.
    always_comb begin
        fwd_sel = FWD_NONE;
        if (match_e_s) begin
            fwd_sel = (e_tnew == {TW{1'b0}}) ? FWD_E : FWD_NONE;
        end else if (match_m_s) begin
            fwd_sel = (m_tnew == {TW{1'b0}}) ? FWD_M : FWD_NONE;
        end else if (match_w_s) begin
            fwd_sel = FWD_W;
        end else begin
            fwd_sel = FWD_NONE;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: tracks E/M/W producers and drives stall, E bubble and all
// forwarding selects. Define HAZARD_STALL_CNT_EN to add the stall_cnt counter port.
module hazard_scoreboard
    import hazard_pkg::*;
`ifdef HAZARD_STALL_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic          d_rs_used,
    input  logic          d_rt_used,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_write,
    input  logic [4:0]    d_waddr,
    output logic          stall,
    output logic          e_bubble,
    output logic [1:0]    fwd_d_rs,
    output logic [1:0]    fwd_d_rt,
    output logic [1:0]    fwd_e_rs,
    output logic [1:0]    fwd_e_rt,
    output logic [1:0]    fwd_m_rt
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    e_stage_t e_r;
    m_stage_t m_r;
    w_stage_t w_r;
    logic     rs_stall_s;
    logic     rt_stall_s;

    hazard_src_check u_rs (
        .src(d_rs), .used(d_rs_used), .tuse(d_tuse_rs),
        .e_wr(e_r.wr), .e_addr(e_r.addr), .e_tnew(e_r.tnew),
        .m_wr(m_r.wr), .m_addr(m_r.addr), .m_tnew(m_r.tnew),
        .w_wr(w_r.wr), .w_addr(w_r.addr),
        .stall_req(rs_stall_s), .fwd_sel(fwd_d_rs)
    );

    hazard_src_check u_rt (
        .src(d_rt), .used(d_rt_used), .tuse(d_tuse_rt),
        .e_wr(e_r.wr), .e_addr(e_r.addr), .e_tnew(e_r.tnew),
        .m_wr(m_r.wr), .m_addr(m_r.addr), .m_tnew(m_r.tnew),
        .w_wr(w_r.wr), .w_addr(w_r.addr),
        .stall_req(rt_stall_s), .fwd_sel(fwd_d_rt)
    );

    assign stall    = rs_stall_s | rt_stall_s;
    assign e_bubble = stall;

    // E-stage operand selects: M beats W, a still-computing M blocks W.
    always_comb begin
        fwd_e_rs = FWD_NONE;
        fwd_e_rt = FWD_NONE;
        fwd_m_rt = FWD_NONE;
        if (m_r.wr && (m_r.addr == e_r.rs) && (e_r.rs != 5'd0)) begin
            fwd_e_rs = (m_r.tnew == {TW{1'b0}}) ? FWD_M : FWD_NONE;
        end else if (w_r.wr && (w_r.addr == e_r.rs) && (e_r.rs != 5'd0)) begin
            fwd_e_rs = FWD_W;
        end else begin
            fwd_e_rs = FWD_NONE;
        end
        if (m_r.wr && (m_r.addr == e_r.rt) && (e_r.rt != 5'd0)) begin
            fwd_e_rt = (m_r.tnew == {TW{1'b0}}) ? FWD_M : FWD_NONE;
        end else if (w_r.wr && (w_r.addr == e_r.rt) && (e_r.rt != 5'd0)) begin
            fwd_e_rt = FWD_W;
        end else begin
            fwd_e_rt = FWD_NONE;
        end
        if (w_r.wr && (w_r.addr == m_r.rt) && (m_r.rt != 5'd0)) begin
            fwd_m_rt = FWD_W;
        end else begin
            fwd_m_rt = FWD_NONE;
        end
    end

    // Stage records advance every cycle; a stall injects a bubble into E only.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_r <= '0;
            m_r <= '0;
            w_r <= '0;
        end else begin
            if (stall) begin
                e_r <= '0;
            end else begin
                e_r <= '{wr: d_write, addr: d_waddr, tnew: d_tnew, rs: d_rs, rt: d_rt};
            end
            m_r <= '{wr: e_r.wr, addr: e_r.addr, tnew: sat_dec(e_r.tnew), rt: e_r.rt};
            w_r <= '{wr: m_r.wr, addr: m_r.addr};
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Free-running count of stalled cycles, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random instruction
// streams, all checked against an in-flight instruction model.
module tb_hazard_scoreboard;

    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_waddr;
    logic       d_rs_used, d_rt_used, d_write;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       stall, e_bubble;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

`ifdef HAZARD_STALL_CNT_EN
    hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew),
        .d_write(d_write), .d_waddr(d_waddr),
        .stall(stall), .e_bubble(e_bubble),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
        .stall_cnt(stall_cnt)
    );
`else
    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew),
        .d_write(d_write), .d_waddr(d_waddr),
        .stall(stall), .e_bubble(e_bubble),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
    );
`endif

    always #5 clk = ~clk;

    // In-flight instructions: index 0 = E, 1 = M, 2 = W. tnew is the decoder value.
    typedef struct {
        bit wr;
        int addr;
        int tnew;
        int rs;
        int rt;
    } instr_t;

    instr_t pipe[3];
    int     cnt_model;
    int     n_cmp = 0;
    int     n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Cycles still needed before stage k's result exists; W is always done.
    function automatic int remaining(input int k);
        if (k >= 2) return 0;
        return (pipe[k].tnew > k) ? pipe[k].tnew - k : 0;
    endfunction

    function automatic bit produces(input int k, input int r);
        return pipe[k].wr && (pipe[k].addr == r) && (r != 0);
    endfunction

    // Nearest producer at or beyond stage 'first' wins; if still computing, no forward.
    function automatic int fwd_from(input int r, input int first);
        for (int k = first; k < 3; k++) begin
            if (produces(k, r)) return (remaining(k) == 0) ? k + 1 : 0;
        end
        return 0;
    endfunction

    function automatic int needs_stall();
        bit s = 0;
        for (int k = 0; k < 2; k++) begin
            if (d_rs_used && produces(k, d_rs) && remaining(k) > d_tuse_rs) s = 1;
            if (d_rt_used && produces(k, d_rt) && remaining(k) > d_tuse_rt) s = 1;
        end
        return int'(s);
    endfunction

    task automatic drive(input int rs, input int rs_used, input int tuse_rs,
                         input int rt, input int rt_used, input int tuse_rt,
                         input int tnew, input int wr, input int waddr);
        d_rs = 5'(rs);       d_rs_used = 1'(rs_used); d_tuse_rs = 2'(tuse_rs);
        d_rt = 5'(rt);       d_rt_used = 1'(rt_used); d_tuse_rt = 2'(tuse_rt);
        d_tnew = 2'(tnew);   d_write = 1'(wr);        d_waddr = 5'(waddr);
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare all outputs with the model, then clock once and advance the model.
    task automatic cycle();
        int s;
        instr_t d;
        #2;
        s = needs_stall();
        check("stall", 32'(stall), 32'(s));
        check("e_bubble", 32'(e_bubble), 32'(s));
        check("fwd_d_rs", 32'(fwd_d_rs), 32'(fwd_from(d_rs, 0)));
        check("fwd_d_rt", 32'(fwd_d_rt), 32'(fwd_from(d_rt, 0)));
        check("fwd_e_rs", 32'(fwd_e_rs), 32'(fwd_from(pipe[0].rs, 1)));
        check("fwd_e_rt", 32'(fwd_e_rt), 32'(fwd_from(pipe[0].rt, 1)));
        check("fwd_m_rt", 32'(fwd_m_rt), 32'(fwd_from(pipe[1].rt, 2)));
`ifdef HAZARD_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(cnt_model));
`endif
        d = '{wr: d_write, addr: int'(d_waddr), tnew: int'(d_tnew),
              rs: int'(d_rs), rt: int'(d_rt)};
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0};
            cnt_model = 0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = s ? '{0, 0, 0, 0, 0} : d;
            cnt_model = (cnt_model + s) % (1 << CNT_W);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0};
        cnt_model = 0;
        reset = 1'b1;
        nop();
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fwd_e_rs", 32'(fwd_e_rs), 32'd0);
        check("rst_fwd_m_rt", 32'(fwd_m_rt), 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        cycle();

        // lw $8 then add reading $8: one stall, then W forwarding into E.
        drive(29, 1, 1, 0, 0, 0, 2, 1, 8);  cycle();
        drive(8, 1, 1, 9, 1, 1, 1, 1, 10);
        #1; check("lw_use_stall", 32'(stall), 32'd1);
        cycle();
        #1; check("lw_use_release", 32'(stall), 32'd0);
        cycle();
        nop();
        #1; check("lw_use_fwd_e_rs", 32'(fwd_e_rs), 32'd3);
        cycle();

        // add $8 then beq on $8: one stall, then M forwarding into D.
        do_reset();
        drive(1, 1, 1, 2, 1, 1, 1, 1, 8);   cycle();
        drive(8, 1, 0, 9, 1, 0, 0, 0, 0);
        #1; check("beq_stall", 32'(stall), 32'd1);
        cycle();
        #1; check("beq_release", 32'(stall), 32'd0);
        check("beq_fwd_d_rs", 32'(fwd_d_rs), 32'd2);
        cycle();

        // jal in E, jr $31 in D: forward straight from E.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 31);  cycle();
        drive(31, 1, 0, 0, 0, 0, 0, 0, 0);
        #1; check("jr_stall", 32'(stall), 32'd0);
        check("jr_fwd_d_rs", 32'(fwd_d_rs), 32'd1);
        cycle();

        // lw $9 in E, sw $9 in D: no stall; store data from W two cycles later.
        do_reset();
        drive(29, 1, 1, 0, 0, 0, 2, 1, 9);  cycle();
        drive(29, 1, 1, 9, 1, 2, 0, 0, 0);
        #1; check("sw_stall", 32'(stall), 32'd0);
        cycle();
        nop();                              cycle();
        #1; check("sw_fwd_m_rt", 32'(fwd_m_rt), 32'd3);
        cycle();

        // Writes to $0 are invisible.
        drive(1, 1, 1, 0, 0, 0, 1, 1, 0);   cycle();
        drive(0, 1, 0, 0, 1, 0, 1, 1, 5);
        #1; check("r0_stall", 32'(stall), 32'd0);
        check("r0_fwd_d_rs", 32'(fwd_d_rs), 32'd0);
        cycle();

        // Reset while stalled discards the producer.
        drive(29, 1, 1, 0, 0, 0, 2, 1, 8);  cycle();
        drive(8, 1, 1, 0, 0, 0, 1, 1, 10);
        #1; check("pre_rst_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1; check("post_rst_stall", 32'(stall), 32'd0);
        cycle();

        // Random instruction streams over a small register set to force collisions.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
            drive($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3));
            cycle();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
